// File: rtl/game_pkg.sv
// Shared definitions for the brick field controller.
//   state_e  : game phase encoding (matches the o_state port encoding)
//   HIT_*    : 2-bit hit/bounce codes (bit1 = flip x, bit0 = flip y)
//   SCORE_W  : score register width
//   LEVEL_W  : level counter width
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PLAY    = 2'b01,
    ST_CLEARED = 2'b10,
    ST_OVER    = 2'b11
  } state_e;

  localparam logic [1:0] HIT_NONE = 2'b00;
  localparam logic [1:0] HIT_V    = 2'b01;
  localparam logic [1:0] HIT_H    = 2'b10;
  localparam logic [1:0] HIT_C    = 2'b11;

  localparam int unsigned SCORE_W = 9;
  localparam int unsigned LEVEL_W = 4;

endpackage

// File: rtl/hit_collector.sv
// Combinational hit collector.
//   i_hit     : per-brick 2-bit hit codes, brick k at [2k+1:2k]
//   i_alive   : alive mask; dead bricks are ignored
//   o_new_hit : bricks that are alive and report a non-zero code
//   o_dir     : OR of the codes of all new hits
//   o_count   : number of new hits
module hit_collector
  import game_pkg::*;
#(
  parameter int unsigned N_BRICKS = 8
) (
  input  logic [2*N_BRICKS-1:0] i_hit,
  input  logic [N_BRICKS-1:0]   i_alive,
  output logic [N_BRICKS-1:0]   o_new_hit,
  output logic [1:0]            o_dir,
  output logic [4:0]            o_count
);

  always_comb begin
    o_new_hit = '0;
    o_dir     = HIT_NONE;
    o_count   = '0;
    for (int unsigned k = 0; k < N_BRICKS; k++) begin
      if ((i_hit[2*k +: 2] != HIT_NONE) && i_alive[k]) begin
        o_new_hit[k] = 1'b1;
        o_dir        = o_dir | i_hit[2*k +: 2];
        o_count      = o_count + 5'd1;
      end
    end
  end

endmodule

// File: rtl/brick_field_ctrl.sv
// Brick field controller: game-phase FSM, alive mask, hit merging into one
// bounce command per animation strobe, score and level counting.
//   i_clk/i_rst     : clock, synchronous active-high reset
//   i_ani_stb       : one-cycle frame strobe
//   i_start         : start/continue request (level)
//   i_endgame       : ball lost
//   i_hit           : per-brick hit codes
//   o_col_detected  : one-cycle ack to bricks
//   o_bounce        : one-cycle bounce command (bit1 flip x, bit0 flip y)
//   o_respawn       : one-cycle brick re-initialise pulse
//   o_alive         : alive mask
//   o_score/o_level : score (saturating) and 0-based level (saturating)
//   o_state/o_clear : game phase and CLEARED flag
module brick_field_ctrl
  import game_pkg::*;
#(
  parameter int unsigned N_BRICKS  = 8,
  parameter int unsigned POINTS    = 1,
  parameter int unsigned SCORE_MAX = 511,
  parameter int unsigned LEVEL_MAX = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ani_stb,
  input  logic                  i_start,
  input  logic                  i_endgame,
  input  logic [2*N_BRICKS-1:0] i_hit,
  output logic                  o_col_detected,
  output logic [1:0]            o_bounce,
  output logic                  o_respawn,
  output logic [N_BRICKS-1:0]   o_alive,
  output logic [SCORE_W-1:0]    o_score,
  output logic [LEVEL_W-1:0]    o_level,
  output logic [1:0]            o_state,
  output logic                  o_clear
);

  state_e               state_q, state_d;
  logic [N_BRICKS-1:0]  alive_q, alive_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [1:0]           pend_q, pend_d;
  logic [1:0]           bounce_q, bounce_d;
  logic                 col_q, col_d;
  logic                 respawn_q, respawn_d;
  logic                 clear_q, clear_d;

  logic [N_BRICKS-1:0]  new_hit;
  logic [1:0]           hit_dir;
  logic [4:0]           hit_cnt;
  logic [13:0]          score_sum;
  logic [SCORE_W-1:0]   score_sat;
  logic                 fire;

  hit_collector #(
    .N_BRICKS (N_BRICKS)
  ) u_hit_collector (
    .i_hit     (i_hit),
    .i_alive   (alive_q),
    .o_new_hit (new_hit),
    .o_dir     (hit_dir),
    .o_count   (hit_cnt)
  );

  assign score_sum = 14'(score_q) + 14'(hit_cnt) * 14'(POINTS);
  assign score_sat = (score_sum > 14'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                  : score_sum[SCORE_W-1:0];
  assign fire      = i_ani_stb && (pend_q != HIT_NONE);

  always_comb begin
    state_d   = state_q;
    alive_d   = alive_q;
    score_d   = score_q;
    level_d   = level_q;
    pend_d    = pend_q;
    bounce_d  = HIT_NONE;
    col_d     = 1'b0;
    respawn_d = 1'b0;
    case (state_q)
      ST_PLAY: begin
        if (fire) begin
          bounce_d = pend_q;
          col_d    = 1'b1;
        end
        // Hits seen on the strobe cycle itself land in the next frame.
        pend_d  = (fire ? HIT_NONE : pend_q) | hit_dir;
        alive_d = alive_q & ~new_hit;
        score_d = score_sat;
        if (i_endgame) begin
          state_d = ST_OVER;
        end else if ((alive_q == '0) && (pend_q == HIT_NONE)) begin
          state_d = ST_CLEARED;
        end
      end
      default: begin
        // Flush a bounce left over from PLAY as a bare ack.
        if (fire) begin
          col_d  = 1'b1;
          pend_d = HIT_NONE;
        end
        if (i_start) begin
          state_d   = ST_PLAY;
          alive_d   = '1;
          respawn_d = 1'b1;
          if (state_q == ST_CLEARED) begin
            level_d = (level_q >= LEVEL_W'(LEVEL_MAX)) ? level_q : level_q + 4'd1;
          end else begin
            score_d = '0;
            level_d = '0;
          end
        end
      end
    endcase
    clear_d = (state_d == ST_CLEARED);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      alive_q   <= '0;
      score_q   <= '0;
      level_q   <= '0;
      pend_q    <= HIT_NONE;
      bounce_q  <= HIT_NONE;
      col_q     <= 1'b0;
      respawn_q <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      alive_q   <= alive_d;
      score_q   <= score_d;
      level_q   <= level_d;
      pend_q    <= pend_d;
      bounce_q  <= bounce_d;
      col_q     <= col_d;
      respawn_q <= respawn_d;
      clear_q   <= clear_d;
    end
  end

  assign o_col_detected = col_q;
  assign o_bounce       = bounce_q;
  assign o_respawn      = respawn_q;
  assign o_alive        = alive_q;
  assign o_score        = score_q;
  assign o_level        = level_q;
  assign o_state        = state_q;
  assign o_clear        = clear_q;

endmodule

// File: tb/tb_brick_field_ctrl.sv
module tb_brick_field_ctrl;

  logic        clk = 1'b0;
  logic        rst, stb, start, endgame;
  logic [15:0] hit;
  logic        col, respawn, clr;
  logic [1:0]  bounce, state;
  logic [7:0]  alive;
  logic [8:0]  score;
  logic [3:0]  level;

  int compared   = 0;
  int mismatched = 0;

  logic [1:0] exp_q[$];
  logic [1:0] sb_e;
  bit         armed = 1'b0;

  logic [7:0] alive_m;
  int         score_m;
  int         level_m;

  brick_field_ctrl #(
    .N_BRICKS  (8),
    .POINTS    (1),
    .SCORE_MAX (511),
    .LEVEL_MAX (15)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_ani_stb      (stb),
    .i_start        (start),
    .i_endgame      (endgame),
    .i_hit          (hit),
    .o_col_detected (col),
    .o_bounce       (bounce),
    .o_respawn      (respawn),
    .o_alive        (alive),
    .o_score        (score),
    .o_level        (level),
    .o_state        (state),
    .o_clear        (clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ack pulse must match the oldest queued bounce.
  always @(negedge clk) begin
    if (armed) begin
      if (col === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("ack_unexpected", 32'(col), 32'd0);
        end else begin
          sb_e = exp_q.pop_front();
          chk("bounce_sb", 32'(bounce), 32'(sb_e));
        end
      end else if (bounce !== 2'b00) begin
        chk("bounce_without_ack", 32'(bounce), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    stb = 1'b1;
    tick();
    stb = 1'b0;
  endtask

  // Drive a hit pattern, hold it one extra cycle, strobe, then release (acked).
  task automatic kill(input logic [15:0] codes);
    logic [1:0] dir;
    int         cnt;
    dir = 2'b00;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (codes[2*k +: 2] != 2'b00 && alive_m[k]) begin
        dir        = dir | codes[2*k +: 2];
        cnt        = cnt + 1;
        alive_m[k] = 1'b0;
      end
    end
    score_m = (score_m + cnt > 511) ? 511 : score_m + cnt;
    if (dir != 2'b00) exp_q.push_back(dir);
    hit = codes;
    tick();
    chk("alive_after_hit", 32'(alive), 32'(alive_m));
    chk("score_after_hit", 32'(score), 32'(score_m));
    tick();
    chk("score_held", 32'(score), 32'(score_m));
    strobe();
    chk("ack_on_strobe", 32'(col), 32'(dir != 2'b00));
    chk("bounce_on_strobe", 32'(bounce), 32'(dir));
    chk("state_during_ack", 32'(state), 32'd1);
    hit = '0;
    tick();
    chk("ack_one_cycle", 32'(col), 32'd0);
  endtask

  task automatic do_start(input bit from_cleared);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (from_cleared) begin
      level_m = (level_m >= 15) ? 15 : level_m + 1;
    end else begin
      level_m = 0;
      score_m = 0;
    end
    alive_m = 8'hFF;
    chk("start_state", 32'(state), 32'd1);
    chk("start_alive", 32'(alive), 32'hFF);
    chk("start_score", 32'(score), 32'(score_m));
    chk("start_level", 32'(level), 32'(level_m));
    chk("respawn_pulse", 32'(respawn), 32'd1);
    tick();
    chk("respawn_low", 32'(respawn), 32'd0);
  endtask

  task automatic next_level();
    logic [15:0] codes;
    for (int k = 0; k < 8; k++) codes[2*k +: 2] = 2'($urandom_range(1, 3));
    kill(codes);
    chk("cleared_state", 32'(state), 32'd2);
    chk("cleared_flag", 32'(clr), 32'd1);
    do_start(1'b1);
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; start = 1'b0; endgame = 1'b0; hit = '0;
    alive_m = 8'h00; score_m = 0; level_m = 0;
    tick();
    tick();
    armed = 1'b1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_alive", 32'(alive), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_col", 32'(col), 32'd0);
    chk("rst_respawn", 32'(respawn), 32'd0);
    chk("rst_clear", 32'(clr), 32'd0);
    rst = 1'b0;
    tick();

    do_start(1'b0);

    // Brick 3 vertical hit
    kill(16'h0040);
    // Brick 0 horizontal + brick 5 vertical in one cycle -> merged corner
    kill(16'h0402);

    // Brick 1 hit coinciding with a strobe: deferred to the next frame
    hit = 16'h0004;
    stb = 1'b1;
    alive_m[1] = 1'b0;
    score_m = score_m + 1;
    exp_q.push_back(2'b01);
    tick();
    stb = 1'b0;
    chk("no_ack_same_strobe", 32'(col), 32'd0);
    chk("alive_same_strobe", 32'(alive), 32'(alive_m));
    tick();
    chk("no_ack_after_same_strobe", 32'(col), 32'd0);
    strobe();
    chk("deferred_ack", 32'(col), 32'd1);
    chk("deferred_bounce", 32'(bounce), 32'd1);
    hit = '0;
    tick();

    // Remaining bricks 2,4,6,7 -> field cleared after the final bounce
    kill(16'hD120);
    chk("clear_state", 32'(state), 32'd2);
    chk("clear_flag", 32'(clr), 32'd1);
    do_start(1'b1);

    // Climb score to 504, then 6 bricks -> 510, then 2 more -> clamp at 511
    while (score_m + 8 <= 510) next_level();
    kill(16'h0555);
    chk("score_510", 32'(score), 32'd510);
    kill(16'hA000);
    chk("score_saturated", 32'(score), 32'd511);
    chk("sat_cleared", 32'(state), 32'd2);
    do_start(1'b1);
    chk("level_saturated", 32'(level), 32'd15);

    // Endgame with a hit pending -> OVER, one bare ack
    hit = 16'h0002;
    alive_m[0] = 1'b0;
    exp_q.push_back(2'b00);
    tick();
    chk("pending_alive", 32'(alive), 32'(alive_m));
    endgame = 1'b1;
    tick();
    endgame = 1'b0;
    chk("over_state", 32'(state), 32'd3);
    chk("over_clear", 32'(clr), 32'd0);
    strobe();
    chk("over_ack", 32'(col), 32'd1);
    chk("over_bounce", 32'(bounce), 32'd0);
    hit = 16'h0008;
    tick();
    chk("over_ack_one_cycle", 32'(col), 32'd0);
    chk("over_hit_ignored", 32'(alive), 32'(alive_m));
    strobe();
    chk("over_no_second_ack", 32'(col), 32'd0);
    hit = '0;
    tick();

    do_start(1'b0);

    // Hit pending when reset arrives: discarded, no ack afterwards
    hit = 16'h0030;
    tick();
    chk("pre_rst_score", 32'(score), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_state", 32'(state), 32'd0);
    chk("rst2_alive", 32'(alive), 32'd0);
    chk("rst2_score", 32'(score), 32'd0);
    chk("rst2_level", 32'(level), 32'd0);
    chk("rst2_clear", 32'(clr), 32'd0);
    chk("rst2_respawn", 32'(respawn), 32'd0);
    hit = '0;
    strobe();
    chk("rst2_no_ack", 32'(col), 32'd0);
    chk("rst2_bounce", 32'(bounce), 32'd0);
    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
